// File: rtl/riscv_regfile_pkg.sv
// Shared types for the RV32 integer register file: register addresses and the issue request.
package riscv_regfile_pkg;

   typedef logic [4:0] regaddr_t;

   localparam regaddr_t REG_ZERO = 5'd0;

   typedef struct packed {
      regaddr_t rs1;
      regaddr_t rs2;
      regaddr_t rd;
      logic     rd_wr;
   } regfile_issue_t;

endpackage

// File: rtl/riscv_regfile_if.sv
// Issue, operand, EXU write-back, flush and scoreboard signals of the register file.
// The master side is the core (IDU/EXU); the slave side is riscv_regfile.
interface riscv_regfile_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
);
   import riscv_regfile_pkg::*;

   logic             issue_vld;
   logic             issue_rdy;
   regaddr_t         issue_rs1;
   regaddr_t         issue_rs2;
   regaddr_t         issue_rd;
   logic             issue_rd_wr;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic             data_vld;
   logic             register_write_en;
   regaddr_t         register_write;
   logic [XLEN-1:0]  register_write_data;
   logic             flush;
   logic [NREGS-1:0] pending;

   modport master (
      output issue_vld, issue_rs1, issue_rs2, issue_rd, issue_rd_wr,
      output register_write_en, register_write, register_write_data, flush,
      input  issue_rdy, rs1_data, rs2_data, data_vld, pending
   );

   modport slave (
      input  issue_vld, issue_rs1, issue_rs2, issue_rd, issue_rd_wr,
      input  register_write_en, register_write, register_write_data, flush,
      output issue_rdy, rs1_data, rs2_data, data_vld, pending
   );

endinterface

// File: rtl/riscv_regfile_scoreboard.sv
// Pending-write scoreboard: RAW/WAW hazard detection, set-over-clear priority and flush.
// RISCV_REGFILE_BYPASS_EN lets a same-cycle write clear the hazard it resolves.
module riscv_regfile_scoreboard
   import riscv_regfile_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  regfile_issue_t   issue,
   input  logic             issue_vld,
   input  logic             flush,
   input  logic             write_en,
   input  regaddr_t         write_addr,
   output logic             issue_rdy,
   output logic             accept,
   output logic [NREGS-1:0] pending
);

   localparam int AW = $clog2(NREGS);
   typedef logic [AW-1:0] idx_t;

   // RV32E ignores the upper address bit, so x16 aliases x0 there.
   idx_t rs1_idx, rs2_idx, rd_idx, wr_idx;
   assign rs1_idx = issue.rs1[AW-1:0];
   assign rs2_idx = issue.rs2[AW-1:0];
   assign rd_idx  = issue.rd[AW-1:0];
   assign wr_idx  = write_addr[AW-1:0];

   logic [NREGS-1:0] clr_vec, set_vec, haz_view, pending_nxt;
   logic             haz;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      clr_vec = '0;
      if (write_en && wr_idx != idx_t'(0))
         clr_vec[wr_idx] = 1'b1;
   end

`ifdef RISCV_REGFILE_BYPASS_EN
   assign haz_view = pending & ~clr_vec;
`else
   assign haz_view = pending;
`endif

   assign haz       = haz_view[rs1_idx] | haz_view[rs2_idx] | (issue.rd_wr & haz_view[rd_idx]);
   assign issue_rdy = reset & ~flush & ~haz;
   assign accept    = issue_vld & issue_rdy;

   always_comb begin
      set_vec = '0;
      if (accept && issue.rd_wr && rd_idx != idx_t'(0))
         set_vec[rd_idx] = 1'b1;
   end

   // A same-cycle set of the register being written back wins over the clear.
   assign pending_nxt = (pending & ~clr_vec) | set_vec;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock) begin
      if (!reset)
         pending <= '0;
      else if (flush)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

endmodule

// File: rtl/riscv_regfile.sv
// RV32 integer register file: storage array, operand read latch and optional write-to-read
// forwarding (RISCV_REGFILE_BYPASS_EN). Hazard tracking lives in riscv_regfile_scoreboard.
module riscv_regfile
   import riscv_regfile_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input logic            clock,
   input logic            reset,
   riscv_regfile_if.slave bus
);

   localparam int AW = $clog2(NREGS);
   typedef logic [AW-1:0] idx_t;

   logic [XLEN-1:0]  regs [NREGS];
   logic [XLEN-1:0]  rd1_val, rd2_val;
   logic [XLEN-1:0]  rs1_q, rs2_q;
   logic             vld_q;
   logic             accept, issue_rdy;
   logic [NREGS-1:0] pending;
   logic             write_hit;
   idx_t             wr_idx, rs1_idx, rs2_idx;
   regfile_issue_t   issue;

   assign issue = '{rs1: bus.issue_rs1, rs2: bus.issue_rs2,
                    rd: bus.issue_rd, rd_wr: bus.issue_rd_wr};

   assign wr_idx    = bus.register_write[AW-1:0];
   assign rs1_idx   = bus.issue_rs1[AW-1:0];
   assign rs2_idx   = bus.issue_rs2[AW-1:0];
   assign write_hit = bus.register_write_en & (wr_idx != idx_t'(REG_ZERO));

   riscv_regfile_scoreboard #(.NREGS(NREGS)) u_scoreboard (
      .clock      (clock),
      .reset      (reset),
      .issue      (issue),
      .issue_vld  (bus.issue_vld),
      .flush      (bus.flush),
      .write_en   (bus.register_write_en),
      .write_addr (bus.register_write),
      .issue_rdy  (issue_rdy),
      .accept     (accept),
      .pending    (pending)
   );

   // NOTE: the array is architecturally reset to zero, so it is built from flops, not a RAM macro.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (write_hit) begin
         regs[wr_idx] <= bus.register_write_data;
      end
   end

   always_comb begin
      rd1_val = (rs1_idx == idx_t'(REG_ZERO)) ? '0 : regs[rs1_idx];
      rd2_val = (rs2_idx == idx_t'(REG_ZERO)) ? '0 : regs[rs2_idx];
`ifdef RISCV_REGFILE_BYPASS_EN
      if (write_hit && wr_idx == rs1_idx) rd1_val = bus.register_write_data;
      if (write_hit && wr_idx == rs2_idx) rd2_val = bus.register_write_data;
`endif
   end

   // Flush and hazards both suppress accept, which also drops data_vld.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rs1_q <= '0;
         rs2_q <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= accept;
         if (accept) begin
            rs1_q <= rd1_val;
            rs2_q <= rd2_val;
         end
      end
   end

   assign bus.issue_rdy = issue_rdy;
   assign bus.pending   = pending;
   assign bus.rs1_data  = rs1_q;
   assign bus.rs2_data  = rs2_q;
   assign bus.data_vld  = vld_q;

endmodule

// File: tb/tb_riscv_regfile.sv
// Directed self-checking bench for riscv_regfile; expectations follow RISCV_REGFILE_BYPASS_EN.
module tb_riscv_regfile;
   import riscv_regfile_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clock = ~clock;

   riscv_regfile_if #(.XLEN(32), .NREGS(32)) bus ();

   riscv_regfile #(.XLEN(32), .NREGS(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_issue(input logic vld, input regaddr_t rs1, input regaddr_t rs2,
                            input regaddr_t rd, input logic wr);
      bus.issue_vld   = vld;
      bus.issue_rs1   = rs1;
      bus.issue_rs2   = rs2;
      bus.issue_rd    = rd;
      bus.issue_rd_wr = wr;
   endtask

   task automatic set_write(input logic en, input regaddr_t addr, input logic [31:0] data);
      bus.register_write_en   = en;
      bus.register_write      = addr;
      bus.register_write_data = data;
   endtask

   initial begin
      bus.flush = 1'b0;
      set_write(1'b0, 5'd0, 32'h0);

      // Reset: issue presented but never ready
      set_issue(1'b1, 5'd5, 5'd6, 5'd0, 1'b0);
      #1;
      check("rdy_in_reset", 32'(bus.issue_rdy), 32'd0);
      tick();
      tick();
      check("rdy_in_reset2", 32'(bus.issue_rdy), 32'd0);
      check("vld_after_reset", 32'(bus.data_vld), 32'd0);
      check("rs1_after_reset", bus.rs1_data, 32'h0);
      check("rs2_after_reset", bus.rs2_data, 32'h0);
      check("pending_after_reset", bus.pending, 32'h0);
      set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      reset = 1'b1;
      #1;
      check("rdy_after_release", 32'(bus.issue_rdy), 32'd1);

      // Write then read, plus back-to-back accepts
      set_write(1'b1, 5'd5, 32'h1234);
      tick();
      set_write(1'b0, 5'd0, 32'h0);
      set_issue(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
      tick();
      check("t2_vld", 32'(bus.data_vld), 32'd1);
      check("t2_rs1", bus.rs1_data, 32'h1234);
      check("t2_rs2_x0", bus.rs2_data, 32'h0);
      set_issue(1'b1, 5'd0, 5'd5, 5'd0, 1'b0);
      tick();
      check("t2_b2b_vld", 32'(bus.data_vld), 32'd1);
      check("t2_b2b_rs2", bus.rs2_data, 32'h1234);
      set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      check("t2_idle_vld", 32'(bus.data_vld), 32'd0);
      check("t2_hold_rs2", bus.rs2_data, 32'h1234);

      // RAW hazard on x7
      set_issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
      tick();
      check("t3_pending7", bus.pending, 32'h0000_0080);
      set_issue(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
      #1;
      check("t3_stall_rdy", 32'(bus.issue_rdy), 32'd0);
      tick();
      check("t3_stall_vld", 32'(bus.data_vld), 32'd0);
      set_write(1'b1, 5'd7, 32'hAA);
      #1;
`ifdef RISCV_REGFILE_BYPASS_EN
      check("t3_write_cycle_rdy", 32'(bus.issue_rdy), 32'd1);
      tick();
      set_write(1'b0, 5'd0, 32'h0);
      check("t3_fwd_vld", 32'(bus.data_vld), 32'd1);
      check("t3_fwd_rs1", bus.rs1_data, 32'hAA);
`else
      check("t3_write_cycle_rdy", 32'(bus.issue_rdy), 32'd0);
      tick();
      set_write(1'b0, 5'd0, 32'h0);
      check("t3_write_cycle_vld", 32'(bus.data_vld), 32'd0);
      #1;
      check("t3_late_rdy", 32'(bus.issue_rdy), 32'd1);
      tick();
      check("t3_late_vld", 32'(bus.data_vld), 32'd1);
      check("t3_late_rs1", bus.rs1_data, 32'hAA);
`endif
      check("t3_pending_clr", bus.pending, 32'h0);
      set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();

      // x0 writes ignored, x0 never pending
      set_write(1'b1, 5'd0, 32'hFFFF_FFFF);
      tick();
      set_write(1'b0, 5'd0, 32'h0);
      set_issue(1'b1, 5'd0, 5'd5, 5'd0, 1'b1);
      #1;
      check("t4_rdy", 32'(bus.issue_rdy), 32'd1);
      tick();
      check("t4_rs1_x0", bus.rs1_data, 32'h0);
      check("t4_rs2_x5", bus.rs2_data, 32'h1234);
      check("t4_pending", bus.pending, 32'h0);

      // Flush with a same-cycle write-back
      set_issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
      tick();
      check("t5_pending3", bus.pending, 32'h0000_0008);
      bus.flush = 1'b1;
      set_write(1'b1, 5'd3, 32'h55);
      set_issue(1'b1, 5'd1, 5'd0, 5'd0, 1'b0);
      #1;
      check("t5_flush_rdy", 32'(bus.issue_rdy), 32'd0);
      tick();
      bus.flush = 1'b0;
      set_write(1'b0, 5'd0, 32'h0);
      check("t5_flush_pending", bus.pending, 32'h0);
      check("t5_flush_vld", 32'(bus.data_vld), 32'd0);
      set_issue(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
      tick();
      check("t5_read_vld", 32'(bus.data_vld), 32'd1);
      check("t5_read_x3", bus.rs1_data, 32'h55);

      // Same-cycle clear and set of x9: set wins
`ifdef RISCV_REGFILE_BYPASS_EN
      set_issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
      tick();
      check("t6_pending9_pre", bus.pending, 32'h0000_0200);
`endif
      set_write(1'b1, 5'd9, 32'h99);
      set_issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
      #1;
      check("t6_rdy", 32'(bus.issue_rdy), 32'd1);
      tick();
      check("t6_set_wins", bus.pending, 32'h0000_0200);
      set_write(1'b1, 5'd9, 32'h9A);
      set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      set_write(1'b0, 5'd0, 32'h0);
      check("t6_pending_clr", bus.pending, 32'h0);
      set_issue(1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
      tick();
      check("t6_read_x9", bus.rs1_data, 32'h9A);
      set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
